dds_sin_qua_gen: RTL and testbench

Sine sample source for the single-channel DAC path. A programmable phase accumulator is advanced at a fixed sample rate and folded through the quarter-wave sine ROM to produce full-wave 12-bit offset-binary codes. Each code is framed with the DAC control nibble and delivered to the SPI DAC writer through its strobe / end-of-write handshake. The block sits directly upstream of the SPI writer and replaces the free-running address counter and FSM as the source of its 16-bit data word.

---
 rtl/dds_sin_qua_gen_pkg.sv | 30 +++
 rtl/rom_sin_qua.sv | 42 ++++
 rtl/dds_sin_qua_gen.sv | 116 +++++++++++
 tb/tb_dds_sin_qua_gen.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_sin_qua_gen_pkg.sv
// Shared types and constants for the DDS quarter-wave sine sample source.
package dds_sin_qua_gen_pkg;

    // Quadrant of the sample phase (top two accumulator bits)
    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    // Sample sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        SEND   = 2'd2,
        WAIT   = 2'd3
    } state_t;

    localparam logic [11:0] MIDSCALE  = 12'h800;
    localparam int          ROM_DEPTH = 1024;
    localparam int          ROM_W     = 12;
    localparam int          ROM_AW    = 10;

    // Odd quadrants walk the quarter-wave table backwards
    function automatic logic [ROM_AW-1:0] fold_addr(input quad_t q, input logic [ROM_AW-1:0] a);
        return (q == Q1 || q == Q3) ? ROM_AW'(ROM_DEPTH - 1) - a : a;
    endfunction

endpackage

// File: rtl/rom_sin_qua.sv
// Quarter-wave sine magnitude ROM, combinational read.
// Entry i = round((2^(Width-1)-1) * sin(pi/2 * i / (Depth-1))), so entry 0 is 0
// and the last entry is full scale. Contents are built at elaboration with
// integer fixed-point Taylor arithmetic so no real types reach synthesis.
module rom_sin_qua #(
    parameter int Width = 12,
    parameter int AddrW = 10
) (
    input  logic [AddrW-1:0] addr,
    output logic [Width-1:0] data
);

    localparam int     Depth  = 1 << AddrW;
    localparam longint PI_Q30 = 64'sd3373259426;

    function automatic logic [Width-1:0] sin_entry(input int idx);
        longint x, x2, t, s, m, amp;
        amp = (longint'(1) <<< (Width - 1)) - 1;
        x   = (PI_Q30 * longint'(idx)) / longint'(2 * (Depth - 1));
        x2  = (x * x) >>> 30;
        t   = x;
        s   = x;
        for (int k = 1; k <= 6; k++) begin
            t = -((t * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            s = s + t;
        end
        m = (amp * s + (longint'(1) <<< 29)) >>> 30;
        if (m > amp) m = amp;
        if (m < 0)   m = 0;
        return Width'(m);
    endfunction

    logic [Width-1:0] table_q [Depth];

    for (genvar i = 0; i < Depth; i++) begin : g_rom
        localparam logic [Width-1:0] M = sin_entry(i);
        assign table_q[i] = M;
    end

    assign data = table_q[addr];

endmodule

// File: rtl/dds_sin_qua_gen.sv
// DDS sine sample source: tick divider, phase accumulator, quadrant fold,
// quarter-wave ROM lookup and strobe / end-of-write handshake to the SPI DAC writer.
module dds_sin_qua_gen
    import dds_sin_qua_gen_pkg::*;
#(
    parameter int          AccW   = 24,
    parameter int          DivMax = 999,
    parameter logic [3:0]  Ctrl   = 4'b1011
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            en_i,
    input  logic [AccW-1:0] fcw_i,
    input  logic            clr_i,
    input  logic            eow_i,
    output logic            strw_o,
    output logic [15:0]     data_o,
    output logic            busy_o,
    output logic            ovr_o
);

    localparam int CntW = (DivMax > 0) ? $clog2(DivMax + 1) : 1;

    logic [CntW-1:0]   tick_cnt;
    logic              tick;
    logic [AccW-1:0]   acc;
    quad_t             phase_q;
    logic [ROM_AW-1:0] phase_a;
    state_t            state, state_nxt;
    quad_t             quad_r;
    logic [ROM_AW-1:0] rom_addr;
    logic [ROM_W-1:0]  rom_mag;
    logic [12:0]       code_ext;
    logic [11:0]       code;

    assign tick    = en_i && (tick_cnt == CntW'(DivMax));
    assign phase_q = quad_t'(acc[AccW-1 -: 2]);
    assign phase_a = acc[AccW-3 -: ROM_AW];
    assign busy_o  = (state != IDLE);

    // Sample-rate divider: held at zero while disabled, wraps after DivMax
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)               tick_cnt <= '0;
        else if (!en_i || tick)  tick_cnt <= '0;
        else                     tick_cnt <= tick_cnt + CntW'(1);
    end

    // Phase advances on every tick, dropped samples included
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)     acc <= '0;
        else if (tick) acc <= acc + fcw_i;
    end

    // Sequencer state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // Sequencer next-state: one sample in flight until the writer reports end of write
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (tick) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = SEND;
            SEND:    state_nxt = WAIT;
            WAIT:    if (eow_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the folded ROM address and sign quadrant of an accepted sample
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            quad_r   <= Q0;
            rom_addr <= '0;
        end else if (state == IDLE && tick) begin
            quad_r   <= phase_q;
            rom_addr <= fold_addr(phase_q, phase_a);
        end
    end

    rom_sin_qua #(
        .Width (ROM_W),
        .AddrW (ROM_AW)
    ) u_rom (
        .addr (rom_addr),
        .data (rom_mag)
    );

    // Offset-binary code: upper half-wave adds, lower subtracts; 13-bit then clamp
    always_comb begin
        code_ext = 13'(MIDSCALE) + 13'(rom_mag);
        if (quad_r == Q2 || quad_r == Q3) code_ext = 13'(MIDSCALE) - 13'(rom_mag);
        code = (code_ext > 13'd4095) ? 12'hFFF : code_ext[11:0];
    end

    // Output word and registered strobe, so strw_o is glitch-free
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_o <= {Ctrl, MIDSCALE};
            strw_o <= 1'b0;
        end else begin
            if (state == LOOKUP) data_o <= {Ctrl, code};
            strw_o <= (state == LOOKUP);
        end
    end

    // Sticky overrun: a tick outside IDLE drops the sample; set beats clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                         ovr_o <= 1'b0;
        else if (tick && state != IDLE)    ovr_o <= 1'b1;
        else if (clr_i)                    ovr_o <= 1'b0;
    end

endmodule

// File: tb/tb_dds_sin_qua_gen.sv
// Self-checking bench for dds_sin_qua_gen with a sample-level reference model.
module tb_dds_sin_qua_gen;

    localparam int DIV = 9;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i  = 1'b0;
    logic [23:0] fcw_i = '0;
    logic        clr_i = 1'b0;
    logic        eow_i;
    logic        strw_o;
    logic [15:0] data_o;
    logic        busy_o;
    logic        ovr_o;

    int n_cmp  = 0;
    int n_fail = 0;

    dds_sin_qua_gen #(.AccW(24), .DivMax(DIV), .Ctrl(4'b1011)) dut (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .fcw_i  (fcw_i),
        .clr_i  (clr_i),
        .eow_i  (eow_i),
        .strw_o (strw_o),
        .data_o (data_o),
        .busy_o (busy_o),
        .ovr_o  (ovr_o)
    );

    always #5 clk_i = ~clk_i;

    // Ideal full-wave sine code for a 24-bit phase
    function automatic int ref_code(input logic [23:0] ph);
        int  q, a, m, c;
        real ang;
        q = int'(ph[23:22]);
        a = int'(ph[21:12]);
        if (q == 1 || q == 3) a = 1023 - a;
        ang = 1.5707963267948966 * real'(a) / 1023.0;
        m = $rtoi(2047.0 * $sin(ang) + 0.5);
        c = (q < 2) ? 2048 + m : 2048 - m;
        if (c > 4095) c = 4095;
        return c;
    endfunction

    // Reference model: one sample in flight, accepted ticks queue their code
    int          cyc = 0;
    int          m_cnt, m_tick_edge;
    logic [23:0] m_acc;
    logic        m_busy, m_ovr;
    int          expq[$];
    wire         m_tick = en_i && (m_cnt == DIV);

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_cnt <= 0; m_acc <= '0; m_busy <= 1'b0; m_ovr <= 1'b0; m_tick_edge <= -100;
            expq.delete();
        end else begin
            m_cnt <= (!en_i || m_tick) ? 0 : m_cnt + 1;
            if (m_tick) m_acc <= m_acc + fcw_i;
            if (m_tick && m_busy) m_ovr <= 1'b1;
            else if (clr_i)       m_ovr <= 1'b0;
            if (m_tick && !m_busy) begin
                expq.push_back(ref_code(m_acc));
                m_busy      <= 1'b1;
                m_tick_edge <= cyc;
            end else if (eow_i && m_busy) begin
                m_busy <= 1'b0;
            end
        end
    end

    // SPI writer stand-in: end-of-write pulse eow_delay cycles after each strobe
    int eow_delay = 3;
    int eow_timer;
    always @(negedge clk_i) begin
        if (rst_i) begin
            eow_i <= 1'b0; eow_timer <= 0;
        end else begin
            eow_i <= 1'b0;
            if (strw_o) eow_timer <= eow_delay;
            else if (eow_timer > 0) begin
                eow_timer <= eow_timer - 1;
                if (eow_timer == 1) eow_i <= 1'b1;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        rst_i = 1'b1; en_i = 1'b0; clr_i = 1'b0; fcw_i = '0; eow_delay = 3;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic drain();
        en_i = 1'b0; clr_i = 1'b0;
        for (int i = 0; i < 60 && busy_o; i++) @(negedge clk_i);
        n_cmp++;
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL drain: busy_o=%b required 0", busy_o); end
    endtask

    task automatic test_reset();
        bit seen = 0;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 40 && !seen; i++) begin @(negedge clk_i); seen = busy_o; end
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        n_cmp += 4;
        if (data_o !== 16'hB800) begin n_fail++; $display("FAIL reset_data: got %h required B800", data_o); end
        if (strw_o !== 1'b0) begin n_fail++; $display("FAIL reset_strw: got %b required 0", strw_o); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy_o); end
        if (ovr_o  !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b required 0", ovr_o); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            n_cmp++;
            if (strw_o !== 1'b0 || busy_o !== 1'b0) begin
                n_fail++; $display("FAIL reset_hold: strw=%b busy=%b required 0 0", strw_o, busy_o);
            end
        end
        rst_i = 1'b0; en_i = 1'b0;
    endtask

    task automatic test_zero_fcw();
        int last = -1, n = 0, e, d;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk_i);
            if (strw_o) begin
                n_cmp++;
                if (data_o !== 16'hB800) begin n_fail++; $display("FAIL zero_data: got %h required B800", data_o); end
                n_cmp++;
                if (expq.size() == 0) begin n_fail++; $display("FAIL zero_model: strobe got, none required"); end
                else begin
                    e = expq.pop_front(); d = int'(data_o[11:0]) - e;
                    if (d > 1 || d < -1) begin n_fail++; $display("FAIL zero_model: got %h required %h", data_o[11:0], e); end
                end
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != DIV + 1) begin n_fail++; $display("FAIL zero_period: got %0d required %0d", cyc - last, DIV + 1); end
                end
                last = cyc; n++;
            end
        end
        n_cmp++;
        if (n < 7) begin n_fail++; $display("FAIL zero_count: got %0d strobes required 7", n); end
        drain();
    endtask

    task automatic test_quarter();
        int pat[4] = '{'h800, 'hFFF, 'h800, 'h001};
        int idx = 0;
        do_reset();
        fcw_i = 24'h400000;
        en_i  = 1'b1;
        for (int i = 0; i < 150 && idx < 8; i++) begin
            @(negedge clk_i);
            if (strw_o) begin
                n_cmp++;
                if (data_o !== {4'hB, 12'(pat[idx % 4])}) begin
                    n_fail++; $display("FAIL quarter_code[%0d]: got %h required %h", idx, data_o, {4'hB, 12'(pat[idx % 4])});
                end
                if (expq.size() > 0) void'(expq.pop_front());
                idx++;
            end
        end
        n_cmp++;
        if (idx != 8) begin n_fail++; $display("FAIL quarter_count: got %0d required 8", idx); end
        drain();
    endtask

    task automatic test_latency();
        int e, d;
        bit hit;
        do_reset();
        en_i = 1'b1;
        for (int s = 0; s < 3; s++) begin
            fcw_i = 24'($urandom);
            hit = 0;
            for (int i = 0; i < 40 && !hit; i++) begin
                @(negedge clk_i);
                hit = (cyc == m_tick_edge + 1);
            end
            n_cmp++;
            if (!hit || busy_o !== 1'b1 || strw_o !== 1'b0) begin
                n_fail++; $display("FAIL lat_t1: hit=%b busy=%b strw=%b required 1 1 0", hit, busy_o, strw_o);
            end
            @(negedge clk_i);
            n_cmp++;
            if (strw_o !== 1'b1) begin n_fail++; $display("FAIL lat_t2_strw: got %b required 1", strw_o); end
            n_cmp++;
            if (expq.size() == 0) begin n_fail++; $display("FAIL lat_t2_data: no sample required"); end
            else begin
                e = expq.pop_front(); d = int'(data_o[11:0]) - e;
                if (data_o[15:12] !== 4'hB || d > 1 || d < -1) begin
                    n_fail++; $display("FAIL lat_t2_data: got %h required %h", data_o, {4'hB, 12'(e)});
                end
            end
            @(negedge clk_i);
            n_cmp++;
            if (strw_o !== 1'b0) begin n_fail++; $display("FAIL lat_t3_strw: got %b required 0", strw_o); end
        end
        drain();
    endtask

    task automatic test_overrun();
        int n = 0, e, d;
        bit got = 0;
        logic [23:0] f, p3;
        do_reset();
        f = 24'($urandom); fcw_i = f; eow_delay = 25; en_i = 1'b1;
        for (int i = 0; i < 60 && !ovr_o; i++) begin
            @(negedge clk_i);
            if (strw_o) begin n++; if (expq.size() > 0) void'(expq.pop_front()); end
        end
        n_cmp += 3;
        if (ovr_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b required 1", ovr_o); end
        if (n != 1) begin n_fail++; $display("FAIL ovr_strobes: got %0d required 1", n); end
        if (ovr_o !== m_ovr) begin n_fail++; $display("FAIL ovr_model: got %b required %b", ovr_o, m_ovr); end
        p3 = 24'(3 * f);
        e  = ref_code(p3);
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk_i);
            if (strw_o) begin
                got = 1;
                if (expq.size() > 0) void'(expq.pop_front());
                d = int'(data_o[11:0]) - e;
                n_cmp++;
                if (d > 1 || d < -1) begin n_fail++; $display("FAIL ovr_skip: got %h required %h", data_o[11:0], e); end
            end
        end
        n_cmp++;
        if (!got) begin n_fail++; $display("FAIL ovr_second: no strobe, one required"); end
        for (int i = 0; i < 20 && m_cnt == DIV; i++) @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        n_cmp++;
        if (ovr_o !== 1'b0 || m_ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b required 0", ovr_o); end
        for (int i = 0; i < 30 && !(m_cnt == DIV && m_busy); i++) @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        n_cmp++;
        if (ovr_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set_wins: got %b required 1", ovr_o); end
        eow_delay = 3;
        drain();
    endtask

    task automatic test_en_drop();
        int n = 0, k = 0;
        bit got = 0;
        do_reset();
        fcw_i = 24'($urandom); eow_delay = 6; en_i = 1'b1;
        for (int i = 0; i < 40 && !got; i++) begin @(negedge clk_i); got = strw_o; end
        if (expq.size() > 0) void'(expq.pop_front());
        @(negedge clk_i);
        en_i = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b1) begin n_fail++; $display("FAIL endrop_busy: got %b required 1", busy_o); end
        for (int i = 0; i < 40; i++) begin @(negedge clk_i); if (strw_o) n++; end
        n_cmp += 2;
        if (n != 0) begin n_fail++; $display("FAIL endrop_strobes: got %0d required 0", n); end
        if (busy_o !== 1'b0) begin n_fail++; $display("FAIL endrop_done: busy=%b required 0", busy_o); end
        en_i = 1'b1;
        for (int i = 0; i < 30 && !busy_o; i++) begin @(negedge clk_i); k++; end
        n_cmp++;
        if (k != DIV + 1) begin n_fail++; $display("FAIL endrop_reen: got %0d cycles required %0d", k, DIV + 1); end
        drain();
        expq.delete();
    endtask

    task automatic test_back_to_back();
        int e, d;
        do_reset();
        fcw_i = 24'($urandom); eow_delay = 8; en_i = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk_i);
            if (strw_o) begin
                n_cmp++;
                if (expq.size() == 0) begin n_fail++; $display("FAIL b2b_data: strobe got, none required"); end
                else begin
                    e = expq.pop_front(); d = int'(data_o[11:0]) - e;
                    if (d > 1 || d < -1) begin n_fail++; $display("FAIL b2b_data: got %h required %h", data_o[11:0], e); end
                end
            end
        end
        n_cmp += 2;
        if (ovr_o !== 1'b1) begin n_fail++; $display("FAIL b2b_ovr: got %b required 1", ovr_o); end
        if (ovr_o !== m_ovr) begin n_fail++; $display("FAIL b2b_model: got %b required %b", ovr_o, m_ovr); end
        eow_delay = 3;
        drain();
    endtask

    task automatic test_random();
        int e, d;
        do_reset();
        en_i = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk_i);
            n_cmp += 2;
            if (busy_o !== m_busy) begin n_fail++; $display("FAIL rnd_busy@%0d: got %b required %b", cyc, busy_o, m_busy); end
            if (ovr_o !== m_ovr) begin n_fail++; $display("FAIL rnd_ovr@%0d: got %b required %b", cyc, ovr_o, m_ovr); end
            if (strw_o) begin
                n_cmp++;
                if (expq.size() == 0) begin n_fail++; $display("FAIL rnd_data: strobe got, none required"); end
                else begin
                    e = expq.pop_front(); d = int'(data_o[11:0]) - e;
                    if (data_o[15:12] !== 4'hB || d > 1 || d < -1) begin
                        n_fail++; $display("FAIL rnd_data: got %h required %h", data_o, {4'hB, 12'(e)});
                    end
                end
            end
            if ($urandom_range(0, 15) == 0) fcw_i = 24'($urandom);
            if ($urandom_range(0, 19) == 0) eow_delay = int'($urandom_range(1, 12));
            if ($urandom_range(0, 49) == 0) en_i = ~en_i;
            clr_i = ($urandom_range(0, 19) == 0);
        end
        eow_delay = 3;
        drain();
    endtask

    initial begin
        test_reset();
        test_zero_fcw();
        test_quarter();
        test_latency();
        test_overrun();
        test_en_drop();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
